// File: rtl/takvim_pkg.sv
// Shared definitions for the calendar setting controller: field codes,
// per-field value ranges, FSM state encoding and the default edit timeout.
// Optional macro SANIYE_SIFIRLA_EN adds a seconds field (code 5): it can be
// set over UART, and commit clears it with a sixth write.
package takvim_pkg;

  localparam int TIMEOUT_S_DEF = 10;

  localparam logic [2:0] F_MIN   = 3'd0;
  localparam logic [2:0] F_HOUR  = 3'd1;
  localparam logic [2:0] F_DAY   = 3'd2;
  localparam logic [2:0] F_MONTH = 3'd3;
  localparam logic [2:0] F_YEAR  = 3'd4;
  localparam logic [2:0] F_SEC   = 3'd5;

`ifdef SANIYE_SIFIRLA_EN
  localparam int         COMMIT_LEN = 6;
  localparam logic [2:0] F_LAST_OK  = F_SEC;
`else
  localparam int         COMMIT_LEN = 5;
  localparam logic [2:0] F_LAST_OK  = F_YEAR;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UART_WR = 2'd1,
    ST_EDIT    = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  // Smallest legal value of a field.
  function automatic logic [6:0] field_min(input logic [2:0] f);
    case (f)
      F_DAY, F_MONTH: field_min = 7'd1;
      default:        field_min = 7'd0;
    endcase
  endfunction

  // Largest legal value of a field; the day limit comes from the caller.
  function automatic logic [6:0] field_max(input logic [2:0] f, input logic [4:0] dim);
    case (f)
      F_MIN:   field_max = 7'd59;
      F_HOUR:  field_max = 7'd23;
      F_DAY:   field_max = {2'b00, dim};
      F_MONTH: field_max = 7'd12;
      F_YEAR:  field_max = 7'd99;
      F_SEC:   field_max = 7'd59;
      default: field_max = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/gun_sayisi.sv
// Days-in-month lookup. February has 29 days when the year is a multiple of
// four (years 2000..2099). Unused month codes map to 31.
module gun_sayisi #(
  parameter int YEAR_W = 7
) (
  input  logic [3:0]        i_ay,
  input  logic [YEAR_W-1:0] i_yil,
  output logic [4:0]        o_gun
);

  // Month/year to number of days.
  always_comb begin
    case (i_ay)
      4'd2:                    o_gun = (i_yil[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: o_gun = 5'd30;
      default:                 o_gun = 5'd31;
    endcase
  end

endmodule

// File: rtl/ayar_denetleyici.sv
// Time/date setting controller. Sequences button-driven editing of the
// calendar fields on a shadow copy, commits the shadow to the timekeeping
// registers as a burst of writes, and arbitrates UART set-commands onto the
// same single write port. Optional macro: SANIYE_SIFIRLA_EN (seconds field).
//
// UART handshake: the requester raises uart_req with uart_field/uart_data
// stable and holds all three until uart_ack; uart_ack is a one-cycle pulse
// (with uart_err when rejected). A request still high the cycle after ack is
// a new request. Requests are only taken in IDLE; during EDIT/COMMIT they
// simply wait.
module ayar_denetleyici
  import takvim_pkg::*;
#(
  parameter int TIMEOUT_S = TIMEOUT_S_DEF,
  parameter int YEAR_W    = 7
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [4:0]        butonlar,
  input  logic [5:0]        cur_min,
  input  logic [4:0]        cur_hour,
  input  logic [4:0]        cur_day,
  input  logic [3:0]        cur_month,
  input  logic [YEAR_W-1:0] cur_year,
  input  logic              uart_req,
  input  logic [2:0]        uart_field,
  input  logic [6:0]        uart_data,
  output logic              uart_ack,
  output logic              uart_err,
  output logic              wr_en,
  output logic [2:0]        wr_field,
  output logic [6:0]        wr_data,
  output logic              edit_active,
  output logic [2:0]        edit_field,
  output logic [6:0]        edit_value,
  output logic              blink,
  output logic [1:0]        dbg_state
);

  localparam int               CNT_W    = $clog2(TIMEOUT_S + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_S - 1);

  state_t           r_state, w_state_nxt;
  logic [6:0]       r_sh [5];
  logic [6:0]       w_sh_nxt [5];
  logic [2:0]       r_field, w_field_nxt;
  logic             r_blink, w_blink_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [6:0]       r_val, w_val_nxt;
  logic [4:0]       w_dim_sh, w_dim_uart;
  logic [6:0]       w_day_commit, w_cur_val, w_lo, w_hi;
  logic             w_uart_ok;

  // Day limit for the shadow copy (edit wrap and commit clamp).
  gun_sayisi #(.YEAR_W(7)) u_dim_sh (
    .i_ay  (r_sh[F_MONTH][3:0]),
    .i_yil (r_sh[F_YEAR]),
    .o_gun (w_dim_sh)
  );

  // Day limit for UART day requests, checked against the live calendar.
  gun_sayisi #(.YEAR_W(YEAR_W)) u_dim_uart (
    .i_ay  (cur_month),
    .i_yil (cur_year),
    .o_gun (w_dim_uart)
  );

  assign w_day_commit = (r_sh[F_DAY] > {2'b00, w_dim_sh}) ? {2'b00, w_dim_sh} : r_sh[F_DAY];
  assign w_cur_val    = r_sh[r_field];
  assign w_lo         = field_min(r_field);
  assign w_hi         = field_max(r_field, w_dim_sh);
  assign w_uart_ok    = (uart_field <= F_LAST_OK) &&
                        (uart_data >= field_min(uart_field)) &&
                        (uart_data <= field_max(uart_field, w_dim_uart));

  assign edit_active = (r_state == ST_EDIT) || (r_state == ST_COMMIT);
  assign edit_field  = r_field;
  assign edit_value  = r_val;
  assign blink       = r_blink;
  assign dbg_state   = r_state;

  // Next-state, shadow update and write-port outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_field_nxt = r_field;
    w_blink_nxt = r_blink;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    uart_ack    = 1'b0;
    uart_err    = 1'b0;
    wr_en       = 1'b0;
    wr_field    = 3'd0;
    wr_data     = 7'd0;
    case (r_state)
      ST_IDLE: begin
        w_blink_nxt = 1'b0;
        if (butonlar[0]) begin
          w_state_nxt       = ST_EDIT;
          w_sh_nxt[F_MIN]   = {1'b0, cur_min};
          w_sh_nxt[F_HOUR]  = {2'b00, cur_hour};
          w_sh_nxt[F_DAY]   = {2'b00, cur_day};
          w_sh_nxt[F_MONTH] = {3'b000, cur_month};
          w_sh_nxt[F_YEAR]  = 7'(cur_year);
          w_field_nxt       = F_MIN;
          w_blink_nxt       = 1'b1;
          w_cnt_nxt         = '0;
        end else if (uart_req) begin
          w_state_nxt = ST_UART_WR;
        end
      end
      ST_UART_WR: begin
        uart_ack = 1'b1;
        if (w_uart_ok) begin
          wr_en    = 1'b1;
          wr_field = uart_field;
          wr_data  = uart_data;
        end else begin
          uart_err = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      ST_EDIT: begin
        // Only the highest-priority pressed button acts: center, then
        // left before right, then up before down.
        if (|butonlar) begin
          w_cnt_nxt   = '0;
          w_blink_nxt = 1'b1;
          if (butonlar[0]) begin
            w_state_nxt = ST_COMMIT;
            w_idx_nxt   = 3'd0;
            w_blink_nxt = 1'b0;
          end else if (butonlar[3]) begin
            w_field_nxt = (r_field == F_MIN) ? F_YEAR : r_field - 3'd1;
          end else if (butonlar[4]) begin
            w_field_nxt = (r_field >= F_YEAR) ? F_MIN : r_field + 3'd1;
          end else if (butonlar[1]) begin
            w_sh_nxt[r_field] = (w_cur_val >= w_hi) ? w_lo : w_cur_val + 7'd1;
          end else begin
            w_sh_nxt[r_field] = (w_cur_val <= w_lo) ? w_hi : w_cur_val - 7'd1;
          end
        end else if (tick_1hz) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_IDLE;
            w_blink_nxt = 1'b0;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_blink_nxt = ~r_blink;
          end
        end
      end
      ST_COMMIT: begin
        wr_en = 1'b1;
        case (r_idx)
          3'd0:    begin wr_field = F_YEAR;  wr_data = r_sh[F_YEAR];  end
          3'd1:    begin wr_field = F_MONTH; wr_data = r_sh[F_MONTH]; end
          3'd2:    begin wr_field = F_DAY;   wr_data = w_day_commit;  end
          3'd3:    begin wr_field = F_HOUR;  wr_data = r_sh[F_HOUR];  end
          3'd4:    begin wr_field = F_MIN;   wr_data = r_sh[F_MIN];   end
          default: begin wr_field = F_SEC;   wr_data = 7'd0;          end
        endcase
        if (r_idx == 3'(COMMIT_LEN - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_val_nxt = ((w_state_nxt == ST_EDIT) || (w_state_nxt == ST_COMMIT)) ?
                w_sh_nxt[w_field_nxt] : 7'd0;
  end

  // State, shadow and edit registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      for (int i = 0; i < 5; i++) r_sh[i] <= 7'd0;
      r_field <= 3'd0;
      r_blink <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_val   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_field <= w_field_nxt;
      r_blink <= w_blink_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_val   <= w_val_nxt;
    end
  end

endmodule

// File: tb/tb_ayar_denetleyici.sv
// Bench for ayar_denetleyici: directed flows plus randomized edit sessions
// and UART commands, checked against a calendar-level reference model and a
// write-port scoreboard.
module tb_ayar_denetleyici;

  localparam int TO = 10;
`ifdef SANIYE_SIFIRLA_EN
  localparam int NCOMMIT = 6;
  localparam bit SEC_EN  = 1'b1;
`else
  localparam int NCOMMIT = 5;
  localparam bit SEC_EN  = 1'b0;
`endif

  logic       CLK, reset, tick_1hz;
  logic [4:0] butonlar;
  logic [5:0] cur_min;
  logic [4:0] cur_hour, cur_day;
  logic [3:0] cur_month;
  logic [6:0] cur_year;
  logic       uart_req;
  logic [2:0] uart_field;
  logic [6:0] uart_data;
  logic       uart_ack, uart_err, wr_en, edit_active, blink;
  logic [2:0] wr_field, edit_field;
  logic [6:0] wr_data, edit_value;
  logic [1:0] dbg_state;

  ayar_denetleyici dut (
    .CLK(CLK), .reset(reset), .tick_1hz(tick_1hz), .butonlar(butonlar),
    .cur_min(cur_min), .cur_hour(cur_hour), .cur_day(cur_day),
    .cur_month(cur_month), .cur_year(cur_year),
    .uart_req(uart_req), .uart_field(uart_field), .uart_data(uart_data),
    .uart_ack(uart_ack), .uart_err(uart_err),
    .wr_en(wr_en), .wr_field(wr_field), .wr_data(wr_data),
    .edit_active(edit_active), .edit_field(edit_field), .edit_value(edit_value),
    .blink(blink), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- counters, scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int n_obs = 0;
  logic [12:0] exp_q[$];
  logic [12:0] act_v, exp_v;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [12:0] ent(input bit ack, input bit err, input bit wr,
                                      input int f, input int d);
    return {ack, err, wr, 3'(f), 7'(d)};
  endfunction

  // Monitor: every ack or write strobe pops one expected entry.
  always @(posedge CLK) begin
    #3;
    if (reset && (uart_ack || wr_en)) begin
      act_v = {uart_ack, uart_err, wr_en, wr_en ? wr_field : 3'd0, wr_en ? wr_data : 7'd0};
      n_obs++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_port_event actual=%h required=none", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL port_event actual=%h required=%h", act_v, exp_v);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  int m_mode;   // 0 idle, 1 editing, 2 committing
  int m_field, m_ticks, m_blink;
  int m_sh[5];
  int c_min, c_hour, c_day, c_month, c_year;

  function automatic int dim_of(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int lo_of(input int f);
    return (f == 2 || f == 3) ? 1 : 0;
  endfunction

  function automatic int hi_of(input int f, input int m, input int y);
    case (f)
      0: return 59;
      1: return 23;
      2: return dim_of(m, y);
      3: return 12;
      4: return 99;
      5: return 59;
      default: return -1;
    endcase
  endfunction

  task automatic set_cur(input int mi, input int h, input int d, input int mo, input int y);
    c_min = mi; c_hour = h; c_day = d; c_month = mo; c_year = y;
    cur_min = 6'(mi); cur_hour = 5'(h); cur_day = 5'(d);
    cur_month = 4'(mo); cur_year = 7'(y);
  endtask

  task automatic rand_cur();
    int mo, y;
    mo = $urandom_range(1, 12);
    y  = $urandom_range(0, 99);
    set_cur($urandom_range(0, 59), $urandom_range(0, 23),
            $urandom_range(1, dim_of(mo, y)), mo, y);
  endtask

  task automatic push_commit();
    int d;
    d = m_sh[2];
    if (d > dim_of(m_sh[3], m_sh[4])) d = dim_of(m_sh[3], m_sh[4]);
    exp_q.push_back(ent(0, 0, 1, 4, m_sh[4]));
    exp_q.push_back(ent(0, 0, 1, 3, m_sh[3]));
    exp_q.push_back(ent(0, 0, 1, 2, d));
    exp_q.push_back(ent(0, 0, 1, 1, m_sh[1]));
    exp_q.push_back(ent(0, 0, 1, 0, m_sh[0]));
    if (SEC_EN) exp_q.push_back(ent(0, 0, 1, 5, 0));
  endtask

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic step(input logic [4:0] b, input bit t);
    int v, lo, hi;
    butonlar = b;
    tick_1hz = t;
    if (m_mode == 0) begin
      if (b[0]) begin
        m_mode = 1; m_field = 0; m_blink = 1; m_ticks = 0;
        m_sh[0] = c_min; m_sh[1] = c_hour; m_sh[2] = c_day;
        m_sh[3] = c_month; m_sh[4] = c_year;
      end
    end else if (m_mode == 1) begin
      if (b != 5'd0) begin
        m_ticks = 0;
        m_blink = 1;
        if (b[0]) begin
          push_commit();
          m_mode = 2;
        end else if (b[3]) begin
          m_field = (m_field + 4) % 5;
        end else if (b[4]) begin
          m_field = (m_field + 1) % 5;
        end else begin
          lo = lo_of(m_field);
          hi = hi_of(m_field, m_sh[3], m_sh[4]);
          v  = m_sh[m_field];
          if (b[1]) v = (v >= hi) ? lo : v + 1;
          else      v = (v <= lo) ? hi : v - 1;
          m_sh[m_field] = v;
        end
      end else if (t) begin
        m_ticks++;
        m_blink = 1 - m_blink;
        if (m_ticks >= TO) m_mode = 0;
      end
    end
    @(negedge CLK);
    butonlar = 5'd0;
    tick_1hz = 1'b0;
    chk("edit_active", edit_active, (m_mode != 0) ? 1 : 0);
    if (m_mode == 1) begin
      chk("edit_field", edit_field, m_field);
      chk("blink", blink, m_blink);
      chk("edit_value", edit_value, m_sh[m_field]);
    end else begin
      chk("blink_off", blink, 0);
    end
  endtask

  task automatic run_commit();
    int n;
    n = 0;
    while (wr_en && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk("commit_len", n, NCOMMIT);
    chk("commit_exit_active", edit_active, 0);
    m_mode = 0;
  endtask

  task automatic uart_cmd(input int f, input int d);
    int n;
    bit ok;
    uart_req = 1'b1;
    uart_field = 3'(f);
    uart_data = 7'(d);
    ok = ((f <= 4) || (SEC_EN && f == 5)) && (d >= lo_of(f)) && (d <= hi_of(f, c_month, c_year));
    exp_q.push_back(ok ? ent(1, 0, 1, f, d) : ent(1, 1, 0, 0, 0));
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!uart_ack && n < 10);
    chk("uart_latency", n, 1);
    chk("uart_err", uart_err, ok ? 0 : 1);
    uart_req = 1'b0;
    @(negedge CLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, uart_ack, 0);
    chk({tag, "_err"}, uart_err, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_field"}, wr_field, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_edit_active"}, edit_active, 0);
    chk({tag, "_edit_field"}, edit_field, 0);
    chk({tag, "_edit_value"}, edit_value, 0);
    chk({tag, "_blink"}, blink, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, obs0, len;
    int r;
    logic [4:0] b;
    reset = 1'b0; tick_1hz = 1'b0; butonlar = 5'd0;
    uart_req = 1'b0; uart_field = 3'd0; uart_data = 7'd0;
    m_mode = 0; m_field = 0; m_ticks = 0; m_blink = 0;
    for (int i = 0; i < 5; i++) m_sh[i] = 0;
    set_cur(0, 0, 1, 1, 0);
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge CLK);

    // Edit flow from 2024-02-29 10:15
    set_cur(15, 10, 29, 2, 24);
    step(5'b00001, 0);
    step(5'b00010, 0);
    step(5'b10000, 0);
    repeat (3) step(5'b00100, 0);
    step(5'b00001, 0);
    run_commit();

    // Day clamp: day 31, month -> 2, year 23 then year 24
    set_cur(0, 0, 31, 1, 23);
    step(5'b00001, 0);
    repeat (3) step(5'b10000, 0);
    step(5'b00010, 0);
    step(5'b00001, 0);
    run_commit();
    step(5'b00001, 0);
    step(5'b01000, 0);
    step(5'b00010, 0);
    step(5'b01000, 0);
    step(5'b00010, 0);
    step(5'b00001, 0);
    run_commit();

    // Timeout, including a press coinciding with a tick
    rand_cur();
    step(5'b00001, 0);
    repeat (3) begin step(5'b00000, 1); step(5'b00000, 0); end
    step(5'b00010, 1);
    repeat (9) begin step(5'b00000, 1); step(5'b00000, 0); end
    chk("timeout_still_editing", edit_active, 1);
    step(5'b00000, 1);
    chk("timeout_exit", edit_active, 0);
    repeat (3) step(5'b00000, 0);

    // UART directed
    set_cur(0, 0, 1, 2, 23);
    uart_cmd(1, 25);
    uart_cmd(0, 30);
    uart_cmd(2, 29);
    uart_cmd(2, 28);
    uart_cmd(5, 0);
    uart_cmd(7, 3);
    uart_cmd(4, 99);
    uart_cmd(3, 0);
    uart_cmd(0, 59);
    uart_cmd(0, 60);

    // Arbitration: request raised during EDIT waits for commit to end
    rand_cur();
    step(5'b00001, 0);
    uart_req = 1'b1; uart_field = 3'd1; uart_data = 7'd12;
    for (int k = 0; k < 6; k++) begin
      step(5'(1 << $urandom_range(1, 4)), 0);
      chk("no_ack_in_edit", uart_ack, 0);
    end
    step(5'b00001, 0);
    exp_q.push_back(ent(1, 0, 1, 1, 12));
    run_commit();
    n = 0;
    while (!uart_ack && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("arb_ack_within_2", (n >= 1 && n <= 2) ? 1 : 0, 1);
    uart_req = 1'b0;
    @(negedge CLK);

    // Random edit sessions interleaved with random UART commands
    for (int s = 0; s < 14; s++) begin
      rand_cur();
      step(5'b00001, 0);
      len = $urandom_range(8, 30);
      for (int k = 0; k < len && m_mode == 1; k++) begin
        r = $urandom_range(0, 9);
        if (r < 7)      b = 5'(1 << $urandom_range(1, 4));
        else if (r < 9) b = 5'd0;
        else            b = 5'($urandom_range(0, 31));
        step(b, ($urandom_range(0, 3) == 0));
      end
      if (m_mode == 1) step(5'b00001, 0);
      if (m_mode == 2) run_commit();
      for (int u = 0; u < 3; u++) begin
        r = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1 && r <= 5) uart_cmd(r, $urandom_range(lo_of(r), 59));
        else uart_cmd(r, $urandom_range(0, 127));
      end
    end

    // Reset during the third commit cycle
    rand_cur();
    step(5'b00001, 0);
    step(5'b00010, 0);
    obs0 = n_obs;
    step(5'b00001, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1 reset = 1'b0;
    #1 chk_all_zero("mid_commit_reset");
    @(negedge CLK);
    chk("writes_before_reset", n_obs - obs0, 2);
    exp_q.delete();
    m_mode = 0;
    reset = 1'b1;
    @(negedge CLK);
    chk_all_zero("after_reset");
    set_cur(0, 0, 1, 1, 20);
    uart_cmd(3, 7);

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ayar_denetleyici.md
Name: ayar_denetleyici

Overview:
- Time/date setting controller for the digital calendar. Sequences button-driven editing of the calendar fields and arbitrates UART set-commands onto the single write port of the timekeeping register block.
- Placed inside saat_guncelleme, between the debounced button pulses / UART command parser and the timekeeping counters.
- Drives the field/value/blink signals used by the 7-segment display mux during edit.

Parameters:
TIMEOUT_S, 10, seconds (tick_1hz pulses) without a button press before EDIT aborts and edits are discarded
YEAR_W, 7, width of year field (0..99 = 2000..2099)

Ports:
CLK  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick_1hz  in  1  one-cycle pulse per second
butonlar  in  5  one-cycle debounced pulses; [0] center, [1] up, [2] down, [3] left, [4] right
cur_min  in  6  live minute
cur_hour  in  5  live hour
cur_day  in  5  live day
cur_month  in  4  live month
cur_year  in  7  live year
uart_req  in  1  UART set request; held high until uart_ack
uart_field  in  3  field code of the request
uart_data  in  7  value of the request
uart_ack  out  1  one-cycle acknowledge
uart_err  out  1  one-cycle pulse with uart_ack when the value is rejected
wr_en  out  1  write strobe to timekeeping registers
wr_field  out  3  field code of the write
wr_data  out  7  write value, zero-extended
edit_active  out  1  high in EDIT/COMMIT; pauses counting
edit_field  out  3  field under edit
edit_value  out  7  shadow value of edit_field
blink  out  1  display blink phase for edit_field

Behaviour:
- Field codes: 0 min (0-59), 1 hour (0-23), 2 day (1..dim), 3 month (1-12), 4 year (0-99).
- dim = days in month; Feb = 29 when year%4==0, else 28.
- Reset (async, reset=0): state IDLE; every output 0; shadow registers 0.
- States:
  - IDLE: center pulse -> EDIT; shadow loaded from cur_* in the same cycle; edit_field=0; blink=1. Otherwise, uart_req -> UART_WR.
  - UART_WR (1 cycle): uart_ack=1.
    - Value in range: wr_en=1, wr_field=uart_field, wr_data=uart_data.
    - Value out of range, or field code >4: uart_err=1, no write.
    - Day is validated against cur_month/cur_year.
    - Returns to IDLE. The requester must drop uart_req; a request still high one cycle after ack is treated as new.
    - Latency: req seen in IDLE at cycle N -> ack at N+1.
  - EDIT:
    - Per cycle, only the highest-priority set bit acts: center > left/right > up/down.
    - left/right: edit_field -/+1, wrapping 0<->4.
    - up/down: shadow value +/-1 with wrap within range (59->0, 0->59, dim->1, 1->dim, 12->1, 99->0).
    - Shadow day is not clamped while month/year change; dim for wrap uses shadow month/year.
    - Any button press clears the idle-second counter and sets blink=1. Each tick_1hz toggles blink and increments the counter.
    - Counter reaching TIMEOUT_S -> IDLE with no writes.
    - center -> COMMIT.
    - uart_req is held pending, with no ack, until IDLE.
  - COMMIT: 5 consecutive cycles with wr_en=1, wr_field 4,3,2,1,0 in order.
    - Written day = min(shadow day, dim(shadow month, shadow year)).
    - Then IDLE; edit_active drops on IDLE entry.
    - Buttons are ignored during COMMIT.
- edit_active=1 in EDIT and COMMIT only. blink=0 outside EDIT.
- edit_value = shadow[edit_field], registered.
- tick_1hz coinciding with a button press: the press wins (counter cleared, blink=1).
- Reset mid-COMMIT: writes already issued stand; remaining writes are dropped.

Optional Feature:
- SANIYE_SIFIRLA_EN defined: COMMIT issues a 6th write, field 5 (seconds) = 0, so commit takes 6 cycles. UART field 5 is accepted with range 0-59.
- Undefined: COMMIT takes 5 cycles; field 5 is rejected with uart_err.

Decomposition:
- takvim_pkg: field code constants, per-field min/max, state encoding, TIMEOUT default.
- Sub-module gun_sayisi: combinational month/year -> dim (5 bits). Instantiated twice: shadow path and UART validation.

Test Plan:
- Edit flow: cur=2024-02-29 10:15; press center, up, right, down x3, center. Expect COMMIT writes (4,24) (3,2) (2,29) (1,7) (0,16) on 5 consecutive cycles.
- Clamp: shadow day 31, month edited to 2, year 23, then center. Expect wr (2,28); with year 24, expect (2,29).
- Timeout: center, then no buttons for 10 tick_1hz pulses. Expect return to IDLE, no wr_en, edit_active=0.
- UART: in IDLE, req field 1 data 25. Expect ack+err at N+1, no write. Req field 0 data 30: ack at N+1 with wr (0,30).
- Arbitration: uart_req raised during EDIT. Expect no ack until COMMIT ends, then ack within 2 cycles of IDLE.
- Reset: assert reset during 3rd COMMIT cycle. Expect all outputs 0 immediately and exactly 2 writes observed.
